// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: round-robin arbiter that applies ClkDiv ratio changes safely (gate, settle, load, resume).
// Optional macro CLK_DIV_CTRL_SAME_SKIP_EN: acknowledge a request for the current ratio without gating.
module clk_div_ctrl #(
  parameter int RATIO_WD      = 8,
  parameter int DEFAULT_RATIO = 2,
  parameter int SETTLE_CYC    = 4
) (
  input  logic                i_ref_clk,
  input  logic                i_rst_n,
  input  logic [1:0]          i_req,
  input  logic [RATIO_WD-1:0] i_req_ratio0,
  input  logic [RATIO_WD-1:0] i_req_ratio1,
  output logic [RATIO_WD-1:0] o_div_ratio,
  output logic                o_clk_en,
  output logic [1:0]          o_gnt,
  output logic                o_err,
  output logic                o_busy
);

  localparam int CNT_WD = $clog2(SETTLE_CYC + 1);

  typedef enum logic [2:0] {START, IDLE, GATE, LOAD, RESUME, ACK} state_t;

  state_t              state_q, state_d;
  logic [CNT_WD-1:0]   cnt_q, cnt_d;
  logic [RATIO_WD-1:0] shadow_q, shadow_d;
  logic                shadow_idx_q, shadow_idx_d;
  logic                rr_ptr_q, rr_ptr_d;
  logic [RATIO_WD-1:0] ratio_d;
  logic                clk_en_d;
  logic [1:0]          gnt_d;
  logic                err_d;
  logic                winner;
  logic [RATIO_WD-1:0] win_ratio;
  logic                reject;
  logic                quick_ack;

  // rr_ptr names the requester that wins a tie; after a grant it moves to the other one.
  always_comb begin
    winner = 1'b0;
    if (i_req == 2'b11) winner = rr_ptr_q;
    else                winner = i_req[1];
    win_ratio = winner ? i_req_ratio1 : i_req_ratio0;
    reject    = (win_ratio == '0);
`ifdef CLK_DIV_CTRL_SAME_SKIP_EN
    quick_ack = reject || (win_ratio == o_div_ratio);
`else
    quick_ack = reject;
`endif
  end

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= START;
      cnt_q        <= '0;
      shadow_q     <= RATIO_WD'(DEFAULT_RATIO);
      shadow_idx_q <= 1'b0;
      rr_ptr_q     <= 1'b0;
      o_div_ratio  <= RATIO_WD'(DEFAULT_RATIO);
      o_clk_en     <= 1'b0;
      o_gnt        <= 2'b00;
      o_err        <= 1'b0;
      o_busy       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      shadow_idx_q <= shadow_idx_d;
      rr_ptr_q     <= rr_ptr_d;
      o_div_ratio  <= ratio_d;
      o_clk_en     <= clk_en_d;
      o_gnt        <= gnt_d;
      o_err        <= err_d;
      o_busy       <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      START:   state_d = IDLE;
      IDLE:    if (i_req != 2'b00) state_d = quick_ack ? ACK : GATE;
      GATE:    if (cnt_q == '0) state_d = LOAD;
      LOAD:    state_d = RESUME;
      RESUME:  state_d = IDLE;
      ACK:     state_d = IDLE;
      default: state_d = START;
    endcase
  end

  // Outputs are computed for the state being entered so every output comes straight from a flop.
  always_comb begin
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    shadow_idx_d = shadow_idx_q;
    rr_ptr_d     = rr_ptr_q;
    ratio_d      = o_div_ratio;
    clk_en_d     = o_clk_en;
    gnt_d        = 2'b00;
    err_d        = 1'b0;
    case (state_q)
      START: clk_en_d = 1'b1;
      IDLE: begin
        clk_en_d = 1'b1;
        if (i_req != 2'b00) begin
          if (quick_ack) begin
            gnt_d[winner] = 1'b1;
            err_d         = reject;
            rr_ptr_d      = ~winner;
          end else begin
            clk_en_d     = 1'b0;
            shadow_d     = win_ratio;
            shadow_idx_d = winner;
            cnt_d        = CNT_WD'(SETTLE_CYC - 1);
          end
        end
      end
      GATE: begin
        clk_en_d = 1'b0;
        if (cnt_q == '0) ratio_d = shadow_q;
        else             cnt_d   = cnt_q - CNT_WD'(1);
      end
      LOAD: begin
        clk_en_d            = 1'b1;
        gnt_d[shadow_idx_q] = 1'b1;
        rr_ptr_d            = ~shadow_idx_q;
      end
      RESUME:  clk_en_d = 1'b1;
      ACK:     clk_en_d = 1'b1;
      default: clk_en_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: randomized self-checking bench for clk_div_ctrl against a transaction-level model.
// Honours CLK_DIV_CTRL_SAME_SKIP_EN the same way the design does.
module tb_clk_div_ctrl;

  localparam int SETTLE = 4;
  localparam logic [7:0] DEF_RATIO = 8'd2;

  logic       i_ref_clk = 1'b0;
  logic       i_rst_n;
  logic [1:0] i_req;
  logic [7:0] i_req_ratio0;
  logic [7:0] i_req_ratio1;
  logic [7:0] o_div_ratio;
  logic       o_clk_en;
  logic [1:0] o_gnt;
  logic       o_err;
  logic       o_busy;

  int num_checks = 0;
  int num_pass   = 0;

  // Model: ratio ClkDiv currently holds, and which requester wins a tie.
  logic [7:0] m_ratio = DEF_RATIO;
  int         m_prio  = 0;

  clk_div_ctrl #(.RATIO_WD(8), .DEFAULT_RATIO(2), .SETTLE_CYC(SETTLE)) dut (
    .i_ref_clk    (i_ref_clk),
    .i_rst_n      (i_rst_n),
    .i_req        (i_req),
    .i_req_ratio0 (i_req_ratio0),
    .i_req_ratio1 (i_req_ratio1),
    .o_div_ratio  (o_div_ratio),
    .o_clk_en     (o_clk_en),
    .o_gnt        (o_gnt),
    .o_err        (o_err),
    .o_busy       (o_busy)
  );

  always #5 i_ref_clk = ~i_ref_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_checks++;
    if (observed === expected) num_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
  endtask

  task automatic checkCycle(input string tag, input logic en, input logic [7:0] ratio,
                            input logic [1:0] gnt, input logic err, input logic busy);
    checkOutput({tag, ".clk_en"}, 32'(o_clk_en), 32'(en));
    checkOutput({tag, ".ratio"},  32'(o_div_ratio), 32'(ratio));
    checkOutput({tag, ".gnt"},    32'(o_gnt), 32'(gnt));
    checkOutput({tag, ".err"},    32'(o_err), 32'(err));
    checkOutput({tag, ".busy"},   32'(o_busy), 32'(busy));
  endtask

  // Entered during an IDLE cycle with requests already driven; follows one transaction to the next IDLE.
  task automatic serveOne();
    int         winner;
    logic [7:0] r;
    logic [1:0] oh;
    bit         quick;
    if (i_req == 2'b11) winner = m_prio;
    else                winner = i_req[1] ? 1 : 0;
    r     = (winner == 1) ? i_req_ratio1 : i_req_ratio0;
    oh    = (winner == 1) ? 2'b10 : 2'b01;
    quick = (r == 8'd0);
`ifdef CLK_DIV_CTRL_SAME_SKIP_EN
    if (r == m_ratio) quick = 1'b1;
`endif
    if (quick) begin
      @(posedge i_ref_clk); @(negedge i_ref_clk);
      checkCycle("ack", 1'b1, m_ratio, oh, (r == 8'd0), 1'b1);
    end else begin
      for (int k = 1; k <= SETTLE + 2; k++) begin
        @(posedge i_ref_clk); @(negedge i_ref_clk);
        checkCycle($sformatf("seq%0d", k), (k == SETTLE + 2),
                   (k >= SETTLE + 1) ? r : m_ratio,
                   (k == SETTLE + 2) ? oh : 2'b00, 1'b0, 1'b1);
      end
    end
    if (r != 8'd0) m_ratio = r;
    m_prio = 1 - winner;
    @(posedge i_ref_clk); #1;
    i_req[winner] = 1'b0;
    @(negedge i_ref_clk);
    checkCycle("idle", 1'b1, m_ratio, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic applyStimulus(input logic [1:0] req, input logic [7:0] r0, input logic [7:0] r1);
    @(posedge i_ref_clk); #1;
    i_req        = req;
    i_req_ratio0 = r0;
    i_req_ratio1 = r1;
    @(negedge i_ref_clk);
    checkCycle("pre", 1'b1, m_ratio, 2'b00, 1'b0, 1'b0);
    while (i_req != 2'b00) serveOne();
  endtask

  function automatic logic [7:0] pickRatio();
    int sel = $urandom_range(0, 3);
    if (sel == 0) return 8'd0;
    if (sel == 1) return m_ratio;
    return 8'($urandom_range(1, 255));
  endfunction

  initial begin
    logic [7:0] r;
    i_rst_n      = 1'b0;
    i_req        = 2'b00;
    i_req_ratio0 = 8'd0;
    i_req_ratio1 = 8'd0;

    // Reset held for three cycles, then one START cycle before IDLE.
    for (int k = 0; k < 3; k++) begin
      @(negedge i_ref_clk);
      checkCycle("rst", 1'b0, DEF_RATIO, 2'b00, 1'b0, 1'b1);
    end
    @(posedge i_ref_clk); #1;
    i_rst_n = 1'b1;
    @(negedge i_ref_clk);
    checkCycle("start", 1'b0, DEF_RATIO, 2'b00, 1'b0, 1'b1);
    @(posedge i_ref_clk); @(negedge i_ref_clk);
    checkCycle("up", 1'b1, DEF_RATIO, 2'b00, 1'b0, 1'b0);

    applyStimulus(2'b01, 8'd5, 8'd0);
    applyStimulus(2'b11, 8'd3, 8'd7);
    applyStimulus(2'b11, 8'd9, 8'd11);
    applyStimulus(2'b10, 8'd0, 8'd0);
    applyStimulus(2'b01, m_ratio, 8'd4);

    // Reset in the second GATE cycle aborts the change; the held request is served afresh.
    r = m_ratio + 8'd1;
    if (r == 8'd0) r = 8'd1;
    @(posedge i_ref_clk); #1;
    i_req        = 2'b01;
    i_req_ratio0 = r;
    @(posedge i_ref_clk); @(negedge i_ref_clk);
    checkCycle("gate1", 1'b0, m_ratio, 2'b00, 1'b0, 1'b1);
    @(posedge i_ref_clk); #1;
    i_rst_n = 1'b0;
    #1;
    checkCycle("abort", 1'b0, DEF_RATIO, 2'b00, 1'b0, 1'b1);
    m_ratio = DEF_RATIO;
    m_prio  = 0;
    @(posedge i_ref_clk); @(negedge i_ref_clk);
    checkCycle("abort_hold", 1'b0, DEF_RATIO, 2'b00, 1'b0, 1'b1);
    @(posedge i_ref_clk); #1;
    i_rst_n = 1'b1;
    @(negedge i_ref_clk);
    checkCycle("restart", 1'b0, DEF_RATIO, 2'b00, 1'b0, 1'b1);
    @(posedge i_ref_clk); @(negedge i_ref_clk);
    checkCycle("reidle", 1'b1, DEF_RATIO, 2'b00, 1'b0, 1'b0);
    while (i_req != 2'b00) serveOne();

    for (int n = 0; n < 40; n++) begin
      logic [1:0] req;
      logic [7:0] r0;
      logic [7:0] r1;
      req = 2'($urandom_range(1, 3));
      r0  = pickRatio();
      r1  = pickRatio();
      applyStimulus(req, r0, r1);
    end

    $display("%0d/%0d checks passed", num_pass, num_checks);
    $finish;
  end

endmodule
